load_store_queue: RTL and testbench
===================================

LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter TAG_W, default 3, width of the instruction tag carried to writeback.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  execute presents a memory op.
REQ-006 SHALL have port in_ready  output  1  queue can accept an op; transfer when in_valid && in_ready.
REQ-007 SHALL have port in_is_store  input  1  1 = store, 0 = load.
REQ-008 SHALL have ports in_addr  input  8  and  in_wdata  input  8  effective address and store data.
REQ-009 SHALL have port in_tag  input  TAG_W  tag of the op.
REQ-010 SHALL have port flush  input  1  discard all queued and in-flight ops.
REQ-011 SHALL have ports mem_address  output  8,  mem_write_data  output  8,  mem_MemWrite  output  1,  mem_MemRead  output  1  driving the downstream memory stage.
REQ-012 SHALL have port mem_read_data  input  8  load data, valid the cycle after mem_MemRead.
REQ-013 SHALL have ports wb_valid  output  1,  wb_data  output  8,  wb_tag  output  TAG_W  registered load result to writeback.

Function
REQ-014 SHALL hold ops in a circular FIFO (head, tail, count), issuing strictly in arrival order; pointers wrap modulo DEPTH.
REQ-015 SHALL drive in_ready = (count < DEPTH) && !flush, from registered count only; no enqueue when full even if dequeuing that cycle.
REQ-016 SHALL run an issue FSM with states IDLE and LOAD_WAIT.
REQ-017 IDLE, head is a store: SHALL assert mem_MemWrite, drive mem_address/mem_write_data from head, and pop head in the same cycle.
REQ-018 IDLE, head is a non-forwarded load: SHALL assert mem_MemRead with mem_address = head address and move to LOAD_WAIT; head stays queued.
REQ-019 LOAD_WAIT: SHALL sample mem_read_data, pop head, return to IDLE, issue nothing to memory; next cycle wb_valid=1, wb_data = sampled value, wb_tag = head tag.
REQ-020 Load latency: SHALL assert wb_valid exactly 2 cycles after the cycle mem_MemRead is high.
REQ-021 SHALL pulse wb_valid for exactly one cycle per completed load; stores SHALL produce no wb_valid.
REQ-022 mem_MemWrite and mem_MemRead SHALL never be high in the same cycle; both low when empty or in LOAD_WAIT.
REQ-023 mem_address and mem_write_data SHALL be 0 when neither strobe is high.
REQ-024 flush SHALL, at that edge, empty the queue, force IDLE, suppress a pending LOAD_WAIT result (no wb_valid), ignore a same-cycle enqueue; memory strobes driven in the flush cycle still occur.

Reset
REQ-025 rst SHALL asynchronously clear head, tail, count to 0 and force IDLE.
REQ-026 During and after reset: in_ready=1 (after release), mem strobes=0, mem_address=0, mem_write_data=0, wb_valid=0, wb_data=0, wb_tag=0.
REQ-027 rst asserted during LOAD_WAIT SHALL discard the load with no wb_valid.

Configuration
REQ-028 Macro LSQ_STORE_FORWARD_EN SHALL enable store-to-load forwarding.
REQ-029 With it: on enqueue of a load, the youngest queued store with equal address (including one popping that cycle) SHALL supply its data; entry marked forwarded.
REQ-030 With it: forwarded load at head in IDLE SHALL pop with no memory strobe; wb_valid next cycle with forwarded data and tag.
REQ-031 Without it: no address comparison; every load issues to memory per REQ-018.

Verification
REQ-032 Reset, then store addr 0x10 data 0xAB -> mem_MemWrite=1, mem_address=0x10, mem_write_data=0xAB one cycle after enqueue; no wb_valid.
REQ-033 Load addr 0x20 tag 5, memory returns 0x3C -> mem_MemRead=1 at cycle N, wb_valid=1, wb_data=0x3C, wb_tag=5 at N+2.
REQ-034 Enqueue 4 loads with issue stalled by LOAD_WAIT (DEPTH=4) -> in_ready=0 at count 4; 5th op held; tags return in order 0,1,2,3.
REQ-035 Flush during LOAD_WAIT with 2 ops queued -> no wb_valid, count=0, in_ready=1 next cycle.
REQ-036 With LSQ_STORE_FORWARD_EN: store 0x40<-0x77 then load 0x40 tag 2 -> load causes no mem_MemRead, wb_data=0x77, wb_tag=2; without macro, mem_MemRead at 0x40 occurs.
REQ-037 Wrap: 9 alternating stores/loads through DEPTH=4 -> all in order, no loss or duplication.

Source files
------------

// File: rtl/load_store_queue.sv
// -----------------------------------------------------------------------------
// load_store_queue
//
// In-order memory-op queue between execute and a single-ported memory stage.
// Ops enter a circular FIFO and leave from the head in arrival order. Stores
// go to memory and retire in the same cycle. Loads strobe mem_MemRead, wait
// one cycle for mem_read_data, then retire with a registered writeback
// (wb_valid / wb_data / wb_tag) one cycle after that.
//
// Optional feature (compile-time macro LSQ_STORE_FORWARD_EN):
//   A load being enqueued takes its data from the youngest queued store to
//   the same address, including a store leaving the head in that same cycle.
//   A forwarded load retires with no memory access, and its writeback
//   follows on the next cycle.
//
// Parameters:
//   DEPTH  queue entries, power of two, 2..16
//   TAG_W  width of the instruction tag carried to writeback
//
// Ports:
//   clk, rst            single clock; asynchronous active-high reset
//   in_valid/in_ready   op handshake from execute (transfer when both high)
//   in_is_store         1 = store, 0 = load
//   in_addr, in_wdata   effective address and store data
//   in_tag              instruction tag
//   flush               discard every queued and in-flight op at this edge
//   mem_address         memory address (0 when no strobe is high)
//   mem_write_data      store data (0 when no strobe is high)
//   mem_MemWrite        store strobe
//   mem_MemRead         load strobe
//   mem_read_data       load data, valid the cycle after mem_MemRead
//   wb_valid            one-cycle pulse per completed load
//   wb_data, wb_tag     load result and its tag
// -----------------------------------------------------------------------------
module load_store_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_store,
  input  logic [7:0]       in_addr,
  input  logic [7:0]       in_wdata,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic [7:0]       mem_address,
  output logic [7:0]       mem_write_data,
  output logic             mem_MemWrite,
  output logic             mem_MemRead,
  input  logic [7:0]       mem_read_data,
  output logic             wb_valid,
  output logic [7:0]       wb_data,
  output logic [TAG_W-1:0] wb_tag
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // For a load, 'data' holds the forwarded store data when 'fwd' is set.
  typedef struct packed {
    logic             is_store;
    logic             fwd;
    logic [7:0]       addr;
    logic [7:0]       data;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  entry_t           queue_mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  state_t           state, state_n;

  entry_t           head_e, new_e;
  logic             push, pop, fwd_pop;
  logic             fwd_hit;
  logic [7:0]       fwd_data;

  assign head_e   = queue_mem[head];
  // Depends on the registered count only: a full queue refuses an op even
  // if the head is leaving in the same cycle.
  assign in_ready = (count < CNT_W'(DEPTH)) && !flush;
  assign push     = in_valid && in_ready;

`ifdef LSQ_STORE_FORWARD_EN
  // Walk from oldest to youngest so the last match (the youngest store) wins.
  // Every occupied entry counts, including the head popping this cycle.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count) begin
        if (queue_mem[head + PTR_W'(i)].is_store &&
            queue_mem[head + PTR_W'(i)].addr == in_addr) begin
          fwd_hit  = 1'b1;
          fwd_data = queue_mem[head + PTR_W'(i)].data;
        end
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_comb begin
    new_e.is_store = in_is_store;
    new_e.fwd      = !in_is_store && fwd_hit;
    new_e.addr     = in_addr;
    new_e.data     = (!in_is_store && fwd_hit) ? fwd_data : in_wdata;
    new_e.tag      = in_tag;
  end

  // Issue logic: memory strobes come straight from the head entry.
  // NOTE: every output of this block gets a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_n        = state;
    pop            = 1'b0;
    fwd_pop        = 1'b0;
    mem_MemWrite   = 1'b0;
    mem_MemRead    = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          if (head_e.is_store) begin
            mem_MemWrite   = 1'b1;
            mem_address    = head_e.addr;
            mem_write_data = head_e.data;
            pop            = 1'b1;
          end else if (head_e.fwd) begin
            pop     = 1'b1;
            fwd_pop = 1'b1;
          end else begin
            mem_MemRead = 1'b1;
            mem_address = head_e.addr;
            state_n     = LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: begin
        // The load stays at the head until its data is captured here.
        pop     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= IDLE;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= IDLE;
    end else begin
      state <= state_n;
      if (pop)  head <= head + PTR_W'(1);
      if (push) tail <= tail + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: the entry storage has no reset; an entry is only read once the
  // count says it was written, so its power-up contents never matter.
  always_ff @(posedge clk) begin
    if (push) queue_mem[tail] <= new_e;
  end

  // Registered writeback. Flush and reset both kill a result in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_tag   <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_tag   <= '0;
    end else if (state == LOAD_WAIT) begin
      wb_valid <= 1'b1;
      wb_data  <= mem_read_data;
      wb_tag   <= head_e.tag;
    end else if (fwd_pop) begin
      wb_valid <= 1'b1;
      wb_data  <= head_e.data;
      wb_tag   <= head_e.tag;
    end else begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_tag   <= '0;
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
// -----------------------------------------------------------------------------
// tb_load_store_queue
//
// Directed bench for load_store_queue (DEPTH=4, TAG_W=3). A queue-level model
// predicts the memory strobes, in_ready and writeback on every cycle. Literal
// expectations for each scenario pin the model. The memory responder returns
// addr ^ 8'h1C only in the cycle after mem_MemRead and 8'hEE in any other
// cycle, so a load that samples in the wrong cycle shows up.
// -----------------------------------------------------------------------------
module tb_load_store_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 3;
`ifdef LSQ_STORE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_is_store;
  logic [7:0]       in_addr;
  logic [7:0]       in_wdata;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic [7:0]       mem_address;
  logic [7:0]       mem_write_data;
  logic             mem_MemWrite;
  logic             mem_MemRead;
  logic [7:0]       mem_read_data;
  logic             wb_valid;
  logic [7:0]       wb_data;
  logic [TAG_W-1:0] wb_tag;

  load_store_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_is_store    (in_is_store),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .in_tag         (in_tag),
    .flush          (flush),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_MemWrite   (mem_MemWrite),
    .mem_MemRead    (mem_MemRead),
    .mem_read_data  (mem_read_data),
    .wb_valid       (wb_valid),
    .wb_data        (wb_data),
    .wb_tag         (wb_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mem_fn(input logic [7:0] a);
    return a ^ 8'h1C;
  endfunction

  // ---------------- model state ----------------
  typedef struct {
    bit               st;
    logic [7:0]       addr;
    logic [7:0]       data;
    logic [TAG_W-1:0] tag;
    bit               fwd;
  } op_t;

  op_t              q[$];
  bit               waiting = 1'b0;
  bit               m_wb_v  = 1'b0;
  logic [7:0]       m_wb_d  = '0;
  logic [TAG_W-1:0] m_wb_t  = '0;

  // observation logs for the literal checks
  int               rd_cyc[$];
  logic [7:0]       rd_addr_log[$];
  logic [7:0]       wr_addr_log[$];
  int               wb_cyc[$];
  logic [7:0]       wb_data_log[$];
  logic [TAG_W-1:0] wb_tag_log[$];
  bit               saw_full = 1'b0;

  // memory responder state
  bit               rd_next = 1'b0;
  logic [7:0]       rd_a    = '0;

  // compare-process scratch
  op_t              hd, nop;
  bit               has, ew, er, m_pop, m_push, n_wb_v;
  logic [7:0]       n_wb_d;
  logic [TAG_W-1:0] n_wb_t;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      waiting = 1'b0;
      m_wb_v  = 1'b0;
      rd_next = 1'b0;
      check("rst_mem_MemWrite",   mem_MemWrite,   0);
      check("rst_mem_MemRead",    mem_MemRead,    0);
      check("rst_mem_address",    mem_address,    0);
      check("rst_mem_write_data", mem_write_data, 0);
      check("rst_wb_valid",       wb_valid,       0);
      check("rst_wb_data",        wb_data,        0);
      check("rst_wb_tag",         wb_tag,         0);
    end else begin
      has = (q.size() != 0);
      if (has) hd = q[0];
      ew = has && !waiting && hd.st;
      er = has && !waiting && !hd.st && !hd.fwd;
      check("mem_MemWrite",   mem_MemWrite,   ew);
      check("mem_MemRead",    mem_MemRead,    er);
      check("mem_address",    mem_address,    (ew || er) ? hd.addr : 8'h00);
      check("mem_write_data", mem_write_data, ew ? hd.data : 8'h00);
      check("in_ready",       in_ready,       (q.size() < DEPTH) && !flush);
      check("wb_valid",       wb_valid,       m_wb_v);
      if (m_wb_v) begin
        check("wb_data", wb_data, m_wb_d);
        check("wb_tag",  wb_tag,  m_wb_t);
      end

      if (mem_MemRead)  begin rd_cyc.push_back(cyc); rd_addr_log.push_back(mem_address); end
      if (mem_MemWrite) wr_addr_log.push_back(mem_address);
      if (wb_valid) begin
        wb_cyc.push_back(cyc);
        wb_data_log.push_back(wb_data);
        wb_tag_log.push_back(wb_tag);
      end
      if (!in_ready) saw_full = 1'b1;
      rd_next = mem_MemRead;
      rd_a    = mem_address;

      // advance the model to the state after the coming rising edge
      n_wb_v = 1'b0;
      n_wb_d = '0;
      n_wb_t = '0;
      m_pop  = 1'b0;
      if (waiting) begin
        m_pop   = 1'b1;
        n_wb_v  = 1'b1;
        n_wb_d  = mem_fn(hd.addr);
        n_wb_t  = hd.tag;
        waiting = 1'b0;
      end else if (has) begin
        if (hd.st) m_pop = 1'b1;
        else if (hd.fwd) begin
          m_pop  = 1'b1;
          n_wb_v = 1'b1;
          n_wb_d = hd.data;
          n_wb_t = hd.tag;
        end else waiting = 1'b1;
      end
      m_push = in_valid && (q.size() < DEPTH) && !flush;
      if (m_push) begin
        nop.st   = in_is_store;
        nop.addr = in_addr;
        nop.data = in_wdata;
        nop.tag  = in_tag;
        nop.fwd  = 1'b0;
        if (!in_is_store && FWD) begin
          for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].st && q[i].addr == in_addr) begin
              nop.fwd  = 1'b1;
              nop.data = q[i].data;
              break;
            end
          end
        end
      end
      if (flush) begin
        q.delete();
        waiting = 1'b0;
        n_wb_v  = 1'b0;
      end else begin
        if (m_pop)  void'(q.pop_front());
        if (m_push) q.push_back(nop);
      end
      m_wb_v = n_wb_v;
      m_wb_d = n_wb_d;
      m_wb_t = n_wb_t;
    end
  end

  // Memory responder: data is valid only in the cycle after mem_MemRead.
  initial begin
    mem_read_data = 8'hEE;
    forever begin
      @(posedge clk);
      #1;
      mem_read_data = rd_next ? mem_fn(rd_a) : 8'hEE;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input bit st, input logic [7:0] a, input logic [7:0] d,
                      input logic [TAG_W-1:0] t);
    bit acc = 1'b0;
    int n   = 0;
    in_valid    = 1'b1;
    in_is_store = st;
    in_addr     = a;
    in_wdata    = d;
    in_tag      = t;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    rd_cyc.delete();
    rd_addr_log.delete();
    wr_addr_log.delete();
    wb_cyc.delete();
    wb_data_log.delete();
    wb_tag_log.delete();
    saw_full = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_is_store = 1'b0;
    in_addr     = '0;
    in_wdata    = '0;
    in_tag      = '0;
    flush       = 1'b0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    // Store 0x10 <- 0xAB: strobe one cycle after enqueue, no writeback
    clear_logs();
    send(1'b1, 8'h10, 8'hAB, 3'd0);
    @(negedge clk);
    check("st_MemWrite", mem_MemWrite,   1);
    check("st_addr",     mem_address,    8'h10);
    check("st_wdata",    mem_write_data, 8'hAB);
    @(posedge clk);
    #1;
    idle(3);
    check("st_no_wb", wb_cyc.size(), 0);

    // Load 0x20 tag 5: memory returns 0x3C, writeback two cycles after MemRead
    clear_logs();
    send(1'b0, 8'h20, 8'h00, 3'd5);
    idle(5);
    check("ld_reads",   rd_cyc.size(), 1);
    check("ld_wbs",     wb_cyc.size(), 1);
    if (rd_cyc.size() == 1 && wb_cyc.size() == 1) begin
      check("ld_rd_addr", rd_addr_log[0], 8'h20);
      check("ld_latency", wb_cyc[0] - rd_cyc[0], 2);
      check("ld_wb_data", wb_data_log[0], 8'h3C);
      check("ld_wb_tag",  wb_tag_log[0], 5);
    end

    // Back-to-back loads fill the queue; tags return in order
    clear_logs();
    for (int i = 0; i < 6; i++) send(1'b0, 8'h30 + 8'(i), 8'h00, TAG_W'(i));
    idle(16);
    check("full_seen", saw_full, 1);
    check("full_wbs",  wb_cyc.size(), 6);
    if (wb_cyc.size() == 6) begin
      for (int i = 0; i < 4; i++) check("full_tag_order", wb_tag_log[i], i);
      check("full_first_data", wb_data_log[0], 8'h2C);
    end

    // Flush during LOAD_WAIT with two ops queued, plus a same-cycle enqueue
    clear_logs();
    send(1'b0, 8'h50, 8'h00, 3'd1);
    send(1'b0, 8'h54, 8'h00, 3'd2);
    flush       = 1'b1;
    in_valid    = 1'b1;
    in_is_store = 1'b1;
    in_addr     = 8'h99;
    in_wdata    = 8'h11;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    check("flush_no_read",  mem_MemRead, 0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_flush_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    idle(5);
    check("flush_no_wb",      wb_cyc.size(), 0);
    check("flush_one_read",   rd_cyc.size(), 1);
    check("flush_enq_ignored", wr_addr_log.size(), 0);

    // Store 0x40 <- 0x77 then load 0x40 tag 2
    clear_logs();
    send(1'b1, 8'h40, 8'h77, 3'd0);
    send(1'b0, 8'h40, 8'h00, 3'd2);
    idle(5);
    check("fw_wbs", wb_cyc.size(), 1);
`ifdef LSQ_STORE_FORWARD_EN
    check("fw_no_read", rd_cyc.size(), 0);
    if (wb_cyc.size() == 1) check("fw_wb_data", wb_data_log[0], 8'h77);
`else
    check("fw_read", rd_cyc.size(), 1);
    if (rd_cyc.size() == 1) check("fw_rd_addr", rd_addr_log[0], 8'h40);
    if (wb_cyc.size() == 1) check("fw_wb_data", wb_data_log[0], 8'h5C);
`endif
    if (wb_cyc.size() == 1) check("fw_wb_tag", wb_tag_log[0], 2);

    // Nine alternating stores/loads wrap the pointers
    clear_logs();
    for (int i = 0; i < 9; i++)
      send((i % 2) == 0, 8'h60 + 8'(i), 8'hA0 + 8'(i), TAG_W'(i));
    idle(14);
    check("wrap_writes", wr_addr_log.size(), 5);
    check("wrap_wbs",    wb_cyc.size(), 4);
    if (wr_addr_log.size() == 5)
      for (int k = 0; k < 5; k++) check("wrap_wr_addr", wr_addr_log[k], 8'h60 + 8'(2 * k));
    if (wb_cyc.size() == 4)
      for (int k = 0; k < 4; k++) begin
        check("wrap_wb_tag",  wb_tag_log[k], 2 * k + 1);
        check("wrap_wb_data", wb_data_log[k], mem_fn(8'h61 + 8'(2 * k)));
      end

    // Reset during LOAD_WAIT discards the load
    clear_logs();
    send(1'b0, 8'h70, 8'h00, 3'd3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_lw_wb", wb_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    check("rst_lw_no_wb", wb_cyc.size(), 0);
    send(1'b1, 8'h11, 8'h22, 3'd0);
    idle(2);
    check("rst_recover_write", wr_addr_log.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
